qkv_stream_scheduler: RTL and testbench
=======================================

# qkv_stream_scheduler

Sequencer that feeds the attention dot-product stage. On a `start` pulse it reads every Q vector from the Q buffer once and, for each Q row, streams all `SEQ_LEN` K/V vector pairs from the K/V buffers. It delivers both streams through valid/ready handshakes, absorbing downstream backpressure with small output FIFOs. It sits between the on-chip Q/K/V SRAM buffers and the dot-product unit's Q, K and V input ports.

## Interface
Parameters:
- `SEQ_LEN`, default `MAX_SEQ_LENGTH`: K/V vectors per Q row; must equal the dot-product row count.
- `NUM_Q`, default 64: Q rows per run.
- `FIFO_DEPTH`, default 3: entries per output FIFO; minimum 2, and 3 sustains 1 vector/cycle.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle run request; honoured only in IDLE.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse at run completion.
- `q_rd_en`  out  1  Q buffer read strobe.
- `q_rd_addr`  out  `$clog2(NUM_Q)` (min 1)  Q row address.
- `q_rd_data`  in  `Q_VECTOR_T`  valid exactly 1 cycle after `q_rd_en`.
- `kv_rd_en`  out  1  K/V buffer read strobe (shared).
- `kv_rd_addr`  out  `$clog2(SEQ_LEN)` (min 1)  K/V row address.
- `k_rd_data`  in  `K_VECTOR_T`  valid 1 cycle after `kv_rd_en`.
- `v_rd_data`  in  `V_VECTOR_T`  valid 1 cycle after `kv_rd_en`.
- `Q_vld_out`  out  1  Q FIFO non-empty.
- `Q_rdy_in`  in  1  downstream Q ready.
- `q_out`  out  `Q_VECTOR_T`  Q FIFO head.
- `K_vld_out`, `V_vld_out`  out  1  both equal KV FIFO non-empty.
- `K_rdy_in`, `V_rdy_in`  in  1  downstream K/V ready.
- `k_out`, `v_out`  out  `K_VECTOR_T`/`V_VECTOR_T`  KV FIFO head.

## Operation
FSM states:
- **IDLE**: on `start`, clear all counters and go to RUN.
- **RUN**: issue reads. When the Q issue count reaches `NUM_Q` and the K/V issue count reaches `NUM_Q*SEQ_LEN`, go to DRAIN.
- **DRAIN**: when the Q sent count equals `NUM_Q` and the K/V sent count equals `NUM_Q*SEQ_LEN`, go to DONE.
- **DONE**: assert `done` for one cycle, then go to IDLE.

Q read issue:
- Issue only in RUN, while fewer than `NUM_Q` Q reads have been issued and `q_occupancy + q_inflight < FIFO_DEPTH`.
- `q_rd_addr` = Q issue count (0..NUM_Q-1).
- `q_inflight` is a 1-bit register set by `q_rd_en`. The returned data is written into the Q FIFO in the cycle it is valid.

K/V read issue:
- Same credit rule, applied to the KV FIFO.
- `kv_rd_addr` counts 0..SEQ_LEN-1 and wraps to 0. Each wrap increments the K/V row-pass counter. Total reads = `NUM_Q*SEQ_LEN`.
- The Q and KV streams are independent; the KV stream may run ahead of the Q stream. Pairing of K/V vectors with Q rows is the consumer's job.

Pops:
- Q FIFO pops on `Q_vld_out && Q_rdy_in`.
- KV FIFO pops only on `K_vld_out && K_rdy_in && V_rdy_in`. K and V always leave together; ready on only one of them pops nothing.
- Push and pop in the same cycle are both honoured, and occupancy is unchanged.
- FIFO full never occurs on a push, because the credit rule guarantees space.
- Output order equals issue order. No vector is dropped or duplicated.

Other rules:
- `start` in any state other than IDLE is ignored, including a `start` in the DONE cycle.
- Sent counters increment on each handshake. Counter widths hold `NUM_Q*SEQ_LEN` without overflow.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; FIFOs empty; counters and in-flight flags cleared. All outputs 0: `busy`, `done`, `q_rd_en`, `kv_rd_en`, both addresses, all valids, and the data outputs.
- Reset mid-run: same as above. Read data returning after reset is discarded. The next `start` restarts at address 0.
- Latency: `start` sampled at edge t, then:
  - `busy` and the first `q_rd_en`/`kv_rd_en` in cycle t+1.
  - Data returns in t+2.
  - `Q_vld_out`/`K_vld_out` first high in t+3.
- Throughput: with ready held high and `FIFO_DEPTH`≥3, one K/V read and one handshake every cycle.
- `done` is asserted in the cycle after the final required handshake, for one cycle. `busy` is low in that cycle.
- Outputs `q_out`/`k_out`/`v_out` are FIFO-head registers and stay stable while valid is high and ready is low.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with `start`=1 → every output 0 and no read strobes.
- **Free-running run** (SEQ_LEN=4, NUM_Q=2, all ready=1, `start` at cycle 0):
  - `q_rd_addr` sequence 0,1 in cycles 1-2.
  - `kv_rd_addr` sequence 0,1,2,3,0,1,2,3 in cycles 1-8.
  - Last K/V handshake in cycle 10, `done`=1 in cycle 11 only.
- **Backpressure** (same config, `K_rdy_in`=`V_rdy_in`=0 in cycles 0-14): exactly 3 `kv_rd_en` pulses are issued, then none. After release, the 8 K/V pairs are delivered in address order and `done` asserts once.
- **Split ready** (`K_rdy_in`=1, `V_rdy_in`=0 for 5 cycles): KV FIFO head stays unchanged and no K/V sent-count increment occurs.
- **Start while busy**: pulse `start` at cycles 0 and 4 → a single run (2 Q and 8 K/V vectors) and one `done` pulse.
- **Reset mid-run**: `rst_n`=0 at cycle 5, then `start` at cycle 7 → outputs 0 in cycle 6, then a clean run with both addresses beginning at 0 in cycle 8.

Source files
------------

// File: rtl/qkv_stream_scheduler.sv
// ---------------------------------------------------------------------------
// qkv_stream_scheduler
//
// Purpose:
//   Sequencer feeding the attention dot-product stage. A start pulse launches
//   a run that reads every Q row from the Q buffer once. For each Q row it
//   streams all SEQ_LEN K/V pairs from the K/V buffers. Both streams leave
//   through valid/ready handshakes. Small output FIFOs absorb downstream
//   backpressure, and a credit rule keeps reads from over-filling them.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle run request (honoured only when idle)
//   busy, done            run in progress / one-cycle completion pulse
//   q_rd_en, q_rd_addr    Q buffer read strobe and row address
//   q_rd_data             Q buffer data, valid one cycle after q_rd_en
//   kv_rd_en, kv_rd_addr  shared K/V buffer read strobe and row address
//   k_rd_data, v_rd_data  K/V buffer data, valid one cycle after kv_rd_en
//   Q_vld_out, Q_rdy_in   Q output handshake, q_out is the Q FIFO head
//   K_vld_out, V_vld_out  K/V output valids (always equal)
//   K_rdy_in, V_rdy_in    K/V output readies; a pair pops only if both high
//   k_out, v_out          K/V FIFO head
// ---------------------------------------------------------------------------

// Small circular FIFO. The caller guarantees that it never pushes when the
// FIFO is full and never pops when it is empty.
module StreamFifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  // Storage is cleared on reset so the head output reads zero afterwards.
  // A simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= (r_wrPtr == LAST) ? '0 : r_wrPtr + PW'(1);
      end
      if (i_pop) r_rdPtr <= (r_rdPtr == LAST) ? '0 : r_rdPtr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;
endmodule

module qkv_stream_scheduler #(
  parameter int SEQ_LEN    = 128,
  parameter int NUM_Q      = 64,
  parameter int FIFO_DEPTH = 3,
  parameter int Q_WIDTH    = 128,
  parameter int K_WIDTH    = 128,
  parameter int V_WIDTH    = 128,
  localparam int QAW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
  localparam int KAW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               q_rd_en,
  output logic [QAW-1:0]     q_rd_addr,
  input  logic [Q_WIDTH-1:0] q_rd_data,
  output logic               kv_rd_en,
  output logic [KAW-1:0]     kv_rd_addr,
  input  logic [K_WIDTH-1:0] k_rd_data,
  input  logic [V_WIDTH-1:0] v_rd_data,
  output logic               Q_vld_out,
  input  logic               Q_rdy_in,
  output logic [Q_WIDTH-1:0] q_out,
  output logic               K_vld_out,
  output logic               V_vld_out,
  input  logic               K_rdy_in,
  input  logic               V_rdy_in,
  output logic [K_WIDTH-1:0] k_out,
  output logic [V_WIDTH-1:0] v_out
);
  localparam int QCW   = $clog2(NUM_Q + 1);
  localparam int TOTAL = NUM_Q * SEQ_LEN;
  localparam int TCW   = $clog2(TOTAL + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [QCW-1:0] NUM_Q_C = QCW'(NUM_Q);
  localparam logic [TCW-1:0] TOTAL_C = TCW'(TOTAL);
  localparam logic [KAW-1:0] KV_LAST = KAW'(SEQ_LEN - 1);
  localparam logic [FCW:0]   DEPTH_C = (FCW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     r_state;
  logic [QCW-1:0] r_qIssued;
  logic [QCW-1:0] r_qSent;
  logic [QCW-1:0] r_kvPass;
  logic [KAW-1:0] r_kvAddr;
  logic [TCW-1:0] r_kvSent;
  logic           r_qInflight;
  logic           r_kvInflight;

  logic [FCW-1:0] w_qCount;
  logic [FCW-1:0] w_kvCount;
  logic [FCW:0]   w_qUsed;
  logic [FCW:0]   w_kvUsed;
  logic           w_qVld;
  logic           w_kvVld;
  logic           w_qPop;
  logic           w_kvPop;
  logic           w_qIssue;
  logic           w_kvIssue;
  logic           w_allIssued;
  logic           w_allSent;
  logic [K_WIDTH+V_WIDTH-1:0] w_kvHead;

  assign w_qVld  = (w_qCount != '0);
  assign w_kvVld = (w_kvCount != '0);
  assign w_qPop  = w_qVld && Q_rdy_in;
  // A K/V pair only leaves when both consumers accept it.
  assign w_kvPop = w_kvVld && K_rdy_in && V_rdy_in;

  // Credit: a read in flight already owns a FIFO slot, so it counts
  // against the space left.
  assign w_qUsed  = {1'b0, w_qCount} + {{FCW{1'b0}}, r_qInflight};
  assign w_kvUsed = {1'b0, w_kvCount} + {{FCW{1'b0}}, r_kvInflight};

  assign w_qIssue  = (r_state == S_RUN) && (r_qIssued < NUM_Q_C) && (w_qUsed < DEPTH_C);
  assign w_kvIssue = (r_state == S_RUN) && (r_kvPass < NUM_Q_C) && (w_kvUsed < DEPTH_C);

  assign w_allIssued = (r_qIssued == NUM_Q_C) && (r_kvPass == NUM_Q_C);
  // Include this cycle's handshake so that done follows the last one
  // without an extra cycle of delay.
  assign w_allSent = ((r_qSent + QCW'(w_qPop)) == NUM_Q_C) &&
                     ((r_kvSent + TCW'(w_kvPop)) == TOTAL_C);

  // Run sequencing. The only exit from IDLE is start, so a start seen in
  // any other state, including DONE, has no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (w_allIssued) r_state <= S_DRAIN;
        S_DRAIN: if (w_allSent) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Issue and sent counters. The in-flight flags mark which cycles carry
  // returning read data. Because reset clears them, data for a read issued
  // before a reset is never captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_qIssued    <= '0;
      r_qSent      <= '0;
      r_kvPass     <= '0;
      r_kvAddr     <= '0;
      r_kvSent     <= '0;
      r_qInflight  <= 1'b0;
      r_kvInflight <= 1'b0;
    end else begin
      r_qInflight  <= w_qIssue;
      r_kvInflight <= w_kvIssue;
      if (r_state == S_IDLE && start) begin
        r_qIssued <= '0;
        r_qSent   <= '0;
        r_kvPass  <= '0;
        r_kvAddr  <= '0;
        r_kvSent  <= '0;
      end else begin
        if (w_qIssue) r_qIssued <= r_qIssued + QCW'(1);
        if (w_kvIssue) begin
          if (r_kvAddr == KV_LAST) begin
            r_kvAddr <= '0;
            r_kvPass <= r_kvPass + QCW'(1);
          end else begin
            r_kvAddr <= r_kvAddr + KAW'(1);
          end
        end
        if (w_qPop) r_qSent <= r_qSent + QCW'(1);
        if (w_kvPop) r_kvSent <= r_kvSent + TCW'(1);
      end
    end
  end

  StreamFifo #(.WIDTH(Q_WIDTH), .DEPTH(FIFO_DEPTH)) u_qFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_qInflight),
    .i_data  (q_rd_data),
    .i_pop   (w_qPop),
    .o_head  (q_out),
    .o_count (w_qCount)
  );

  // K and V share one FIFO so they can never drift apart.
  StreamFifo #(.WIDTH(K_WIDTH + V_WIDTH), .DEPTH(FIFO_DEPTH)) u_kvFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_kvInflight),
    .i_data  ({k_rd_data, v_rd_data}),
    .i_pop   (w_kvPop),
    .o_head  (w_kvHead),
    .o_count (w_kvCount)
  );

  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_DONE);
  assign q_rd_en    = w_qIssue;
  assign q_rd_addr  = r_qIssued[QAW-1:0];
  assign kv_rd_en   = w_kvIssue;
  assign kv_rd_addr = r_kvAddr;
  assign Q_vld_out  = w_qVld;
  assign K_vld_out  = w_kvVld;
  assign V_vld_out  = w_kvVld;
  assign k_out      = w_kvHead[K_WIDTH+V_WIDTH-1:V_WIDTH];
  assign v_out      = w_kvHead[V_WIDTH-1:0];
endmodule

// File: tb/tb_qkv_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_qkv_stream_scheduler
//
// Purpose:
//   Self-checking bench for qkv_stream_scheduler with SEQ_LEN=4, NUM_Q=2 and
//   FIFO_DEPTH=3. Behavioural Q/K/V buffers return random contents one cycle
//   after each read strobe. The reference model is the expected stream
//   itself: Q rows 0..NUM_Q-1, then NUM_Q passes over K/V rows
//   0..SEQ_LEN-1. Every valid output head is compared against the next
//   expected vector.
// ---------------------------------------------------------------------------
module tb_qkv_stream_scheduler;
  localparam int SEQ_LEN    = 4;
  localparam int NUM_Q      = 2;
  localparam int FIFO_DEPTH = 3;
  localparam int DW         = 16;
  localparam int TOTAL      = NUM_Q * SEQ_LEN;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          q_rd_en;
  logic [0:0]    q_rd_addr;
  logic [DW-1:0] q_rd_data;
  logic          kv_rd_en;
  logic [1:0]    kv_rd_addr;
  logic [DW-1:0] k_rd_data;
  logic [DW-1:0] v_rd_data;
  logic          Q_vld_out;
  logic          Q_rdy_in;
  logic [DW-1:0] q_out;
  logic          K_vld_out;
  logic          V_vld_out;
  logic          K_rdy_in;
  logic          V_rdy_in;
  logic [DW-1:0] k_out;
  logic [DW-1:0] v_out;
  logic [57:0]   outVec;

  logic [DW-1:0] qMem [NUM_Q];
  logic [DW-1:0] kMem [SEQ_LEN];
  logic [DW-1:0] vMem [SEQ_LEN];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int qIdx      = 0;
  int kvIdx     = 0;
  int doneCount = 0;
  int lastHsCyc = 0;
  int kvPulses  = 0;

  qkv_stream_scheduler #(
    .SEQ_LEN    (SEQ_LEN),
    .NUM_Q      (NUM_Q),
    .FIFO_DEPTH (FIFO_DEPTH),
    .Q_WIDTH    (DW),
    .K_WIDTH    (DW),
    .V_WIDTH    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .q_rd_en    (q_rd_en),
    .q_rd_addr  (q_rd_addr),
    .q_rd_data  (q_rd_data),
    .kv_rd_en   (kv_rd_en),
    .kv_rd_addr (kv_rd_addr),
    .k_rd_data  (k_rd_data),
    .v_rd_data  (v_rd_data),
    .Q_vld_out  (Q_vld_out),
    .Q_rdy_in   (Q_rdy_in),
    .q_out      (q_out),
    .K_vld_out  (K_vld_out),
    .V_vld_out  (V_vld_out),
    .K_rdy_in   (K_rdy_in),
    .V_rdy_in   (V_rdy_in),
    .k_out      (k_out),
    .v_out      (v_out)
  );

  assign outVec = {busy, done, q_rd_en, kv_rd_en, q_rd_addr, kv_rd_addr,
                   Q_vld_out, K_vld_out, V_vld_out, q_out, k_out, v_out};

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, used to time done against the last handshake.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAMs: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    q_rd_data <= q_rd_en ? qMem[q_rd_addr] : DW'($urandom);
    k_rd_data <= kv_rd_en ? kMem[kv_rd_addr] : DW'($urandom);
    v_rd_data <= kv_rd_en ? vMem[kv_rd_addr] : DW'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReady(input logic q, input logic k, input logic v);
    Q_rdy_in = q;
    K_rdy_in = k;
    V_rdy_in = v;
  endtask

  task automatic clearModel();
    qIdx      = 0;
    kvIdx     = 0;
    doneCount = 0;
  endtask

  // Row index in the top nibble keeps vectors within one buffer distinct.
  task automatic randomizeMem();
    for (int i = 0; i < NUM_Q; i++) qMem[i] = {4'(i), 12'($urandom)};
    for (int i = 0; i < SEQ_LEN; i++) begin
      kMem[i] = {4'(i), 12'($urandom)};
      vMem[i] = {4'(i), 12'($urandom)};
    end
  endtask

  // Runs cycles until done is seen or the budget expires. Random mode
  // toggles the readies and throws stray start pulses at the busy design.
  task automatic applyStimulus(input int budget, input bit randomMode);
    int n;
    n = 0;
    while (doneCount == 0 && n < budget) begin
      stepCycle();
      n++;
      if (doneCount != 0) begin
        start = 1'b0;
      end else if (randomMode) begin
        Q_rdy_in = ($urandom_range(0, 3) != 0);
        K_rdy_in = ($urandom_range(0, 3) != 0);
        V_rdy_in = ($urandom_range(0, 3) != 0);
        start    = ($urandom_range(0, 7) == 0);
      end else begin
        setReady(1'b1, 1'b1, 1'b1);
        start = 1'b0;
      end
    end
    start = 1'b0;
    setReady(1'b1, 1'b1, 1'b1);
    checkOutput("runFinished", 64'(doneCount), 64'(1));
  endtask

  task automatic checkRunEnd();
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("endQCount", 64'(qIdx), 64'(NUM_Q));
    checkOutput("endKvCount", 64'(kvIdx), 64'(TOTAL));
    checkOutput("endDoneCount", 64'(doneCount), 64'(1));
    checkOutput("endBusy", 64'(busy), 64'(0));
  endtask

  // Scoreboard: each valid head must be the next vector of the expected
  // stream. Heads advance only on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (Q_vld_out) begin
        checkOutput("qWithinRun", 64'(qIdx < NUM_Q), 64'(1));
        if (qIdx < NUM_Q) checkOutput("qHead", 64'(q_out), 64'(qMem[qIdx]));
        if (Q_rdy_in) begin
          qIdx++;
          lastHsCyc = cyc;
        end
      end
      if (K_vld_out) begin
        checkOutput("vVldPair", 64'(V_vld_out), 64'(1));
        checkOutput("kvWithinRun", 64'(kvIdx < TOTAL), 64'(1));
        if (kvIdx < TOTAL) begin
          checkOutput("kHead", 64'(k_out), 64'(kMem[kvIdx % SEQ_LEN]));
          checkOutput("vHead", 64'(v_out), 64'(vMem[kvIdx % SEQ_LEN]));
        end
        if (K_rdy_in && V_rdy_in) begin
          kvIdx++;
          lastHsCyc = cyc;
        end
      end
      if (done) begin
        doneCount++;
        checkOutput("doneAfterLastHs", 64'(cyc), 64'(lastHsCyc + 1));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    setReady(1'b1, 1'b1, 1'b1);
    randomizeMem();

    // Reset held with start high: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("resetOutputs", 64'(outVec), 64'(0));
    end
    stepCycle();
    rst_n = 1'b1;
    start = 1'b0;
    stepCycle();

    // Free-running run: start in cycle 0, addresses and done timed exactly.
    $display("[TB] free-running run");
    clearModel();
    randomizeMem();
    for (int c = 0; c < 14; c++) begin
      stepCycle();
      start = (c == 0);
      @(negedge clk);
      checkOutput("frQEn", 64'(q_rd_en), 64'(c == 1 || c == 2));
      if (c == 1 || c == 2) checkOutput("frQAddr", 64'(q_rd_addr), 64'(c - 1));
      checkOutput("frKvEn", 64'(kv_rd_en), 64'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) checkOutput("frKvAddr", 64'(kv_rd_addr), 64'((c - 1) % SEQ_LEN));
      checkOutput("frBusy", 64'(busy), 64'(c >= 1 && c <= 10));
      checkOutput("frDone", 64'(done), 64'(c == 11));
    end
    checkRunEnd();

    // Backpressure: K/V readies low for 15 cycles; credits allow 3 reads.
    $display("[TB] backpressure run");
    clearModel();
    randomizeMem();
    kvPulses = 0;
    for (int c = 0; c < 15; c++) begin
      stepCycle();
      start = (c == 0);
      setReady(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (kv_rd_en) kvPulses++;
    end
    checkOutput("bpKvPulses", 64'(kvPulses), 64'(3));
    applyStimulus(100, 1'b0);
    checkRunEnd();

    // Split ready: K ready alone must not pop the K/V head.
    $display("[TB] split-ready run");
    clearModel();
    randomizeMem();
    for (int c = 0; c < 8; c++) begin
      stepCycle();
      start = (c == 0);
      setReady(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (c >= 3) begin
        checkOutput("splitKVld", 64'(K_vld_out), 64'(1));
        checkOutput("splitKHead", 64'(k_out), 64'(kMem[0]));
        checkOutput("splitVHead", 64'(v_out), 64'(vMem[0]));
      end
    end
    applyStimulus(100, 1'b0);
    checkRunEnd();

    // Start while busy: the second pulse is ignored.
    $display("[TB] start-while-busy run");
    clearModel();
    randomizeMem();
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      start = (c == 0 || c == 4);
      setReady(1'b1, 1'b1, 1'b1);
      @(negedge clk);
    end
    applyStimulus(100, 1'b0);
    checkRunEnd();

    // Reset mid-run, then a clean restart from address 0.
    $display("[TB] reset mid-run");
    clearModel();
    randomizeMem();
    for (int c = 0; c <= 8; c++) begin
      stepCycle();
      start = (c == 0 || c == 7);
      rst_n = (c != 5);
      setReady(1'b1, 1'b1, 1'b1);
      if (c == 7) clearModel();
      @(negedge clk);
      if (c == 6) checkOutput("midResetOutputs", 64'(outVec), 64'(0));
      if (c == 8) begin
        checkOutput("restartQEn", 64'(q_rd_en), 64'(1));
        checkOutput("restartQAddr", 64'(q_rd_addr), 64'(0));
        checkOutput("restartKvEn", 64'(kv_rd_en), 64'(1));
        checkOutput("restartKvAddr", 64'(kv_rd_addr), 64'(0));
      end
    end
    applyStimulus(100, 1'b0);
    checkRunEnd();

    // Randomized runs: random readies and stray start pulses.
    for (int r = 0; r < 6; r++) begin
      $display("[TB] random run %0d", r);
      clearModel();
      randomizeMem();
      stepCycle();
      start = 1'b1;
      applyStimulus(400, 1'b1);
      checkRunEnd();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
